// File: rtl/gray_sched.sv
// -----------------------------------------------------------------------------
// gray_sched
//   Shares one 3-bit Gray-code counter between two requesters. Each requester
//   asks for a run of N counter steps. Owners are picked round-robin. For the
//   granted job the scheduler clears the counter, drives exactly N enable
//   cycles, then captures the counter's Output/Overflow with a one-cycle Done
//   pulse.
//
// Ports
//   Clk       in   system clock, rising edge
//   Reset_n   in   asynchronous active-low reset
//   Req       in   [1:0] level request per requester (bit0 = requester 0)
//   Steps0    in   [STEP_W-1:0] step count of requester 0, sampled at grant
//   Steps1    in   [STEP_W-1:0] step count of requester 1, sampled at grant
//   Grant     out  [1:0] one-hot owner, CLEAR through DONE
//   Done      out  [1:0] one-hot one-cycle pulse in DONE
//   Busy      out  high in any state except IDLE
//   Result    out  [2:0] counter Output captured in DONE
//   ResOvf    out  counter Overflow captured in DONE
//   CntEn     out  counter enable
//   CntReset  out  counter synchronous clear (active high)
//   CntOut    in   [2:0] counter Output
//   CntOvf    in   counter Overflow (sticky)
// -----------------------------------------------------------------------------
module gray_sched #(
  parameter int STEP_W = 4
) (
  input  logic              Clk,
  input  logic              Reset_n,
  input  logic [1:0]        Req,
  input  logic [STEP_W-1:0] Steps0,
  input  logic [STEP_W-1:0] Steps1,
  output logic [1:0]        Grant,
  output logic [1:0]        Done,
  output logic              Busy,
  output logic [2:0]        Result,
  output logic              ResOvf,
  output logic              CntEn,
  output logic              CntReset,
  input  logic [2:0]        CntOut,
  input  logic              CntOvf
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_CLEAR = 2'd1,
    S_RUN   = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t            r_state;
  logic              r_own;
  logic              r_last;
  logic [STEP_W-1:0] r_rem;
  logic [1:0]        r_grant;
  logic [1:0]        r_done;
  logic              r_busy;
  logic [2:0]        r_result;
  logic              r_res_ovf;
  logic              r_cnt_en;
  logic              r_cnt_reset;

  logic              w_any;
  logic              w_pick;
  logic [STEP_W-1:0] w_steps;

  function automatic logic [1:0] onehot(input logic idx);
    return idx ? 2'b10 : 2'b01;
  endfunction

  // A single request wins outright; on a tie the requester that was not
  // served last wins.
  always_comb begin
    w_any   = |Req;
    w_pick  = 1'b0;
    if (Req == 2'b10)
      w_pick = 1'b1;
    else if (Req == 2'b11)
      w_pick = ~r_last;
    w_steps = w_pick ? Steps1 : Steps0;
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_state     <= S_IDLE;
      r_own       <= 1'b0;
      r_last      <= 1'b1;   // requester 0 wins the first tie
      r_rem       <= '0;
      r_grant     <= 2'b00;
      r_done      <= 2'b00;
      r_busy      <= 1'b0;
      r_result    <= 3'b000;
      r_res_ovf   <= 1'b0;
      r_cnt_en    <= 1'b0;
      r_cnt_reset <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_done <= 2'b00;
          if (w_any) begin
            r_own       <= w_pick;
            r_rem       <= w_steps;
            r_grant     <= onehot(w_pick);
            r_busy      <= 1'b1;
            r_cnt_reset <= 1'b1;
            r_state     <= S_CLEAR;
          end
        end
        S_CLEAR: begin
          r_cnt_reset <= 1'b0;
          if (r_rem != '0) begin
            r_cnt_en <= 1'b1;
            r_state  <= S_RUN;
          end else begin
            r_done  <= onehot(r_own);
            r_state <= S_DONE;
          end
        end
        S_RUN: begin
          // Rem is at least 1 here, so the decrement never wraps.
          r_rem <= r_rem - STEP_W'(1);
          if (r_rem == STEP_W'(1)) begin
            r_cnt_en <= 1'b0;
            r_done   <= onehot(r_own);
            r_state  <= S_DONE;
          end
        end
        S_DONE: begin
          // Counter outputs settled one cycle after the last enabled edge.
          r_result  <= CntOut;
          r_res_ovf <= CntOvf;
          r_last    <= r_own;
          r_done    <= 2'b00;
          r_grant   <= 2'b00;
          r_busy    <= 1'b0;
          r_state   <= S_IDLE;
        end
        default: begin
          r_done      <= 2'b00;
          r_grant     <= 2'b00;
          r_busy      <= 1'b0;
          r_cnt_en    <= 1'b0;
          r_cnt_reset <= 1'b0;
          r_state     <= S_IDLE;
        end
      endcase
    end
  end

  assign Grant    = r_grant;
  assign Done     = r_done;
  assign Busy     = r_busy;
  assign Result   = r_result;
  assign ResOvf   = r_res_ovf;
  assign CntEn    = r_cnt_en;
  assign CntReset = r_cnt_reset;

endmodule

// File: tb/tb_gray_sched.sv
// -----------------------------------------------------------------------------
// tb_gray_sched
//   Bench for gray_sched with a behavioural 3-bit Gray counter attached to the
//   scheduler's counter ports. Expected job results are pushed to a scoreboard
//   queue when a request is driven and popped when Done pulses.
// -----------------------------------------------------------------------------
module tb_gray_sched;
  localparam int STEP_W = 4;

  logic              Clk = 1'b0;
  logic              Reset_n;
  logic [1:0]        Req;
  logic [STEP_W-1:0] Steps0;
  logic [STEP_W-1:0] Steps1;
  logic [1:0]        Grant;
  logic [1:0]        Done;
  logic              Busy;
  logic [2:0]        Result;
  logic              ResOvf;
  logic              CntEn;
  logic              CntReset;
  logic [2:0]        CntOut;
  logic              CntOvf;

  int tests = 0;
  int fails = 0;
  int en_cnt = 0;
  int gnt_cnt = 0;
  int done_cnt = 0;

  // Entry layout: [5:4] owner one-hot, [3:1] Result, [0] ResOvf
  logic [5:0] sb[$];

  gray_sched #(.STEP_W(STEP_W)) dut (
    .Clk(Clk), .Reset_n(Reset_n), .Req(Req), .Steps0(Steps0), .Steps1(Steps1),
    .Grant(Grant), .Done(Done), .Busy(Busy), .Result(Result), .ResOvf(ResOvf),
    .CntEn(CntEn), .CntReset(CntReset), .CntOut(CntOut), .CntOvf(CntOvf)
  );

  always #5 Clk = ~Clk;

  // Behavioural Gray counter: sync clear, enable steps, sticky overflow on wrap.
  logic [2:0] cb = 3'd0;
  logic       cov = 1'b0;
  always @(posedge Clk) begin
    if (CntReset) begin
      cb  <= 3'd0;
      cov <= 1'b0;
    end else if (CntEn) begin
      cb <= cb + 3'd1;
      if (cb == 3'd7) cov <= 1'b1;
    end
  end
  assign CntOut = cb ^ {1'b0, cb[2:1]};
  assign CntOvf = cov;

  always @(posedge Clk) begin
    if (CntEn) en_cnt <= en_cnt + 1;
    if (Grant != 2'b00) gnt_cnt <= gnt_cnt + 1;
    if (Done != 2'b00) done_cnt <= done_cnt + 1;
  end

  function automatic logic [5:0] exp_of(input logic own, input int n);
    logic [2:0] b;
    logic [2:0] g;
    b = 3'(n % 8);
    g = b ^ (b >> 1);
    return {(own ? 2'b10 : 2'b01), g, (n >= 8)};
  endfunction

  task automatic wait_done(output logic ok);
    ok = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(negedge Clk);
      if (Done != 2'b00) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic sb_pop(output logic [5:0] e, output logic ok);
    ok = (sb.size() != 0);
    e  = ok ? sb.pop_front() : 6'h00;
  endtask

  task automatic test_reset();
    Reset_n = 1'b0; Req = 2'b00; Steps0 = '0; Steps1 = '0;
    repeat (3) @(negedge Clk);
    tests++;
    if ({Grant, Done, Busy, Result, ResOvf, CntEn, CntReset} !== 11'd0) begin
      fails++;
      $display("FAIL reset_outputs: got %b required 0", {Grant, Done, Busy, Result, ResOvf, CntEn, CntReset});
    end
    Reset_n = 1'b1;
    @(negedge Clk);
    tests++;
    if (Busy !== 1'b0 || Grant !== 2'b00) begin
      fails++;
      $display("FAIL idle_after_reset: busy=%b grant=%b required 0/00", Busy, Grant);
    end
  endtask

  task automatic test_single();
    logic ok, pok;
    logic [5:0] e;
    int e0, g0;
    Steps0 = 4'd5; Req = 2'b01;
    sb.push_back(exp_of(1'b0, 5));
    e0 = en_cnt; g0 = gnt_cnt;
    #1;
    tests++;
    if (Grant !== 2'b00) begin
      fails++;
      $display("FAIL single_no_comb_grant: grant=%b required 00", Grant);
    end
    @(negedge Clk);
    tests++;
    if (Grant !== 2'b01 || CntReset !== 1'b1 || Busy !== 1'b1 || CntEn !== 1'b0) begin
      fails++;
      $display("FAIL single_clear: grant=%b rst=%b busy=%b en=%b required 01/1/1/0", Grant, CntReset, Busy, CntEn);
    end
    wait_done(ok);
    Req = 2'b00;
    sb_pop(e, pok);
    tests++;
    if (!ok || !pok || Done !== e[5:4]) begin
      fails++;
      $display("FAIL single_done: done=%b required %b (seen=%b)", Done, e[5:4], ok);
    end
    @(negedge Clk);
    tests++;
    if ({Result, ResOvf} !== e[3:0] || Grant !== 2'b00) begin
      fails++;
      $display("FAIL single_result: res=%b ovf=%b grant=%b required %b/%b/00", Result, ResOvf, Grant, e[3:1], e[0]);
    end
    tests++;
    if (en_cnt - e0 != 5 || gnt_cnt - g0 != 7) begin
      fails++;
      $display("FAIL single_cycles: en=%0d grant=%0d required 5/7", en_cnt - e0, gnt_cnt - g0);
    end
  endtask

  task automatic test_overflow();
    int steps[2] = '{9, 3};
    logic ok, pok;
    logic [5:0] e;
    for (int k = 0; k < 2; k++) begin
      Steps1 = 4'(steps[k]); Req = 2'b10;
      sb.push_back(exp_of(1'b1, steps[k]));
      wait_done(ok);
      Req = 2'b00;
      sb_pop(e, pok);
      tests++;
      if (!ok || !pok || Done !== e[5:4]) begin
        fails++;
        $display("FAIL ovf_done[%0d]: done=%b required %b (seen=%b)", k, Done, e[5:4], ok);
      end
      @(negedge Clk);
      tests++;
      if ({Result, ResOvf} !== e[3:0]) begin
        fails++;
        $display("FAIL ovf_result[%0d]: res=%b ovf=%b required %b/%b", k, Result, ResOvf, e[3:1], e[0]);
      end
    end
  endtask

  task automatic test_round_robin();
    logic ok, pok;
    logic [5:0] e;
    Steps0 = 4'd2; Steps1 = 4'd4; Req = 2'b11;
    for (int k = 0; k < 4; k++) sb.push_back(exp_of(k[0], (k % 2 == 0) ? 2 : 4));
    for (int k = 0; k < 4; k++) begin
      wait_done(ok);
      if (k == 3) Req = 2'b00;
      sb_pop(e, pok);
      tests++;
      if (!ok || !pok || Done !== e[5:4]) begin
        fails++;
        $display("FAIL rr_done[%0d]: done=%b required %b (seen=%b)", k, Done, e[5:4], ok);
      end
      @(negedge Clk);
      tests++;
      if ({Result, ResOvf} !== e[3:0] || Grant !== 2'b00 || Busy !== 1'b0) begin
        fails++;
        $display("FAIL rr_idle[%0d]: res=%b ovf=%b grant=%b busy=%b required %b/%b/00/0", k, Result, ResOvf, Grant, Busy, e[3:1], e[0]);
      end
      if (k < 3) begin
        @(negedge Clk);
        tests++;
        if (Grant !== sb[0][5:4]) begin
          fails++;
          $display("FAIL rr_regrant[%0d]: grant=%b required %b", k, Grant, sb[0][5:4]);
        end
      end
    end
  endtask

  task automatic test_zero_steps();
    logic ok, pok;
    logic [5:0] e;
    int e0, g0;
    Steps0 = 4'd0; Req = 2'b01;
    sb.push_back(exp_of(1'b0, 0));
    e0 = en_cnt; g0 = gnt_cnt;
    wait_done(ok);
    Req = 2'b00;
    sb_pop(e, pok);
    tests++;
    if (!ok || !pok || Done !== e[5:4]) begin
      fails++;
      $display("FAIL zero_done: done=%b required %b (seen=%b)", Done, e[5:4], ok);
    end
    @(negedge Clk);
    tests++;
    if ({Result, ResOvf} !== e[3:0] || en_cnt - e0 != 0 || gnt_cnt - g0 != 2) begin
      fails++;
      $display("FAIL zero_job: res=%b ovf=%b en=%0d grant=%0d required %b/%b/0/2", Result, ResOvf, en_cnt - e0, gnt_cnt - g0, e[3:1], e[0]);
    end
  endtask

  task automatic test_max_steps();
    logic ok, pok;
    logic [5:0] e;
    Steps0 = 4'd15; Req = 2'b01;
    sb.push_back(exp_of(1'b0, 15));
    @(negedge Clk);
    @(negedge Clk);
    Steps0 = 4'd3;
    wait_done(ok);
    Req = 2'b00;
    sb_pop(e, pok);
    tests++;
    if (!ok || !pok || Done !== e[5:4]) begin
      fails++;
      $display("FAIL max_done: done=%b required %b (seen=%b)", Done, e[5:4], ok);
    end
    @(negedge Clk);
    tests++;
    if ({Result, ResOvf} !== e[3:0]) begin
      fails++;
      $display("FAIL max_result: res=%b ovf=%b required %b/%b", Result, ResOvf, e[3:1], e[0]);
    end
  endtask

  task automatic test_reset_mid_run();
    logic ok, pok, hit;
    logic [5:0] e;
    int e0, d0;
    Steps0 = 4'd8; Req = 2'b01;
    e0 = en_cnt; d0 = done_cnt;
    hit = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge Clk);
      if (en_cnt - e0 == 3) begin
        hit = 1'b1;
        break;
      end
    end
    tests++;
    if (!hit) begin
      fails++;
      $display("FAIL midrun_reach: en=%0d required 3", en_cnt - e0);
    end
    Reset_n = 1'b0;
    Req = 2'b00;
    #1;
    tests++;
    if ({Grant, Done, Busy, Result, ResOvf, CntEn, CntReset} !== 11'd0) begin
      fails++;
      $display("FAIL midrun_async: got %b required 0", {Grant, Done, Busy, Result, ResOvf, CntEn, CntReset});
    end
    repeat (2) @(negedge Clk);
    tests++;
    if (done_cnt != d0) begin
      fails++;
      $display("FAIL midrun_no_done: pulses=%0d required 0", done_cnt - d0);
    end
    Reset_n = 1'b1;
    @(negedge Clk);
    Steps0 = 4'd1; Steps1 = 4'd2; Req = 2'b11;
    sb.push_back(exp_of(1'b0, 1));
    sb.push_back(exp_of(1'b1, 2));
    for (int k = 0; k < 2; k++) begin
      wait_done(ok);
      if (k == 1) Req = 2'b00;
      sb_pop(e, pok);
      tests++;
      if (!ok || !pok || Done !== e[5:4]) begin
        fails++;
        $display("FAIL post_reset_done[%0d]: done=%b required %b (seen=%b)", k, Done, e[5:4], ok);
      end
      @(negedge Clk);
      tests++;
      if ({Result, ResOvf} !== e[3:0]) begin
        fails++;
        $display("FAIL post_reset_result[%0d]: res=%b ovf=%b required %b/%b", k, Result, ResOvf, e[3:1], e[0]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    @(negedge Clk);
    test_overflow();
    @(negedge Clk);
    test_round_robin();
    @(negedge Clk);
    test_zero_steps();
    @(negedge Clk);
    test_max_steps();
    @(negedge Clk);
    test_reset_mid_run();
    repeat (2) @(negedge Clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

endmodule
